iq_mixer_pipelined: RTL and testbench
=====================================

// Module: iq_mixer_pipelined
// PURPOSE
//  Parametrised I/Q mixer: multiplies an RF sample stream (1-bit sigma-delta or multi-bit two's complement)
//  by NCO sine/cosine. Produces rounded, gain-scaled, saturated I/Q outputs with valid qualification.
//  Keeps a sticky saturation flag and a saturation counter.
//  Sits between the NCO and the CIC decimators; rf_out feeds the sigma-delta feedback pin.
// PARAMETERS
//  LO_WIDTH      12  width of signed sinewave_in/cosinewave_in
//  RF_WIDTH      1   width of rf_in; 1 = sign mode (0 -> +1, 1 -> -1); >1 = signed Q1.(RF_WIDTH-1)
//  OUT_WIDTH     12  width of signed sinewave_out/cosinewave_out
//  RF_DELAY      2   clocks from rf_in to the multiplier (LO/RF alignment); legal range 1..8
//  GAIN_SHIFT_W  2   width of gain_shift (left shift 0..2^GAIN_SHIFT_W-1)
//  SAT_CNT_W     16  width of sat_count
// PORTS
//  clk             in   1             clock; single domain
//  rst             in   1             synchronous, active-high reset
//  rf_in           in   RF_WIDTH      RF sample; sampled every clk
//  in_valid        in   1             qualifies sinewave_in/cosinewave_in this cycle
//  sinewave_in     in   LO_WIDTH      signed NCO sine
//  cosinewave_in   in   LO_WIDTH      signed NCO cosine
//  gain_shift      in   GAIN_SHIFT_W  post-multiply left shift; quasi-static
//  clear_sat       in   1             1-cycle pulse; clears sat_flag and sat_count
//  rf_out          out  RF_WIDTH      rf_in delayed 1 clk
//  out_valid       out  1             sinewave_out/cosinewave_out hold a new sample
//  sinewave_out    out  OUT_WIDTH     signed mixed sine product
//  cosinewave_out  out  OUT_WIDTH     signed mixed cosine product
//  sat_flag        out  1             sticky: a valid output saturated
//  sat_count       out  SAT_CNT_W     count of saturated valid outputs; sticks at all-ones
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): the following take effect at that edge and override any in-flight data.
//   - rf delay line, rf_out, pipeline regs, outputs, sat_flag, sat_count all go to 0.
//   - out_valid goes to 0.
//   - In sign mode a zeroed delay line means +1.
//  RF path:
//   - The delay line shifts every clk regardless of in_valid.
//   - The multiplier uses rf_in delayed RF_DELAY clks.
//   - rf_out is the tap at 1 clk.
//  Stage 1 (edge where in_valid=1):
//   - prod_s = sin*rf and prod_c = cos*rf, each LO_WIDTH+RF_WIDTH bits.
//   - Sign mode: prod = +/-lo exactly. Negating -2^(LO_WIDTH-1) is representable in this width.
//   - gain_shift is captured with the sample, so a mid-stream change applies to whole samples only.
//  Stage 2:
//   - Scaled value: v = prod <<< shift.
//   - Let D = RF_WIDTH-1. If D>0, add 2^(D-1), then arithmetic right shift by D (round half toward +inf).
//   - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; I and Q saturate independently.
//  Handshake and latency:
//   - out_valid = in_valid delayed 2 clks. No backpressure.
//   - When out_valid=0, outputs hold their previous value.
//  Saturation reporting:
//   - sat = either channel clipped on a valid output.
//   - When sat: sat_flag <= 1; sat_count increments, held at all-ones.
//   - clear_sat zeroes both. If clear_sat and sat occur in the same cycle: sat_flag=1, sat_count=1 (set wins).
//  All arithmetic is signed. There is no wrap-around anywhere.
// STRUCTURE
//  Package iq_mixer_pkg:
//   - function sat_round(value, drop, out_w) constants.
//   - localparam PROD_W = LO_WIDTH+RF_WIDTH.
//   - localparam SCALED_W = PROD_W+2^GAIN_SHIFT_W-1.
//  Sub-module mixer_scale_sat: shift/round/saturate for one channel; registered output plus a sat bit.
//   - Instantiated twice (I, Q).
//  Top module holds the rf delay line, stage-1 multiplies, valid pipe and saturation counter.
// TESTING
//  1. RF_WIDTH=1, RF_DELAY=2, shift=0, rf=0, sin=100, cos=-200, in_valid=1
//     -> 2 clks later out_valid=1, sin_out=100, cos_out=-200.
//  2. Same, rf=1 -> sin_out=-100, cos_out=200. Then sin=-2048, rf=1 -> sin_out=2047, sat_flag=1, sat_count=1.
//  3. RF_WIDTH=8, rf=64, sin=1000 -> 500.
//     rf=1, sin=64 -> 1; sin=-64 -> 0; sin=63 -> 0.
//     rf=-128, sin=-2048 -> 2047 with sat.
//  4. RF_WIDTH=1, gain_shift=2, sin=600, rf=0 -> 2047 sat.
//     gain_shift=1, sin=-300 -> -600. Changing shift mid-stream never splits a sample.
//  5. rf_in toggles 0101..., in_valid=1 constantly:
//     - rf_out matches rf_in one clk late.
//     - Output signs follow rf delayed RF_DELAY+2 clks.
//     - in_valid gaps produce out_valid gaps 2 clks later.
//  6. rst asserted while full -> next edge out_valid=0, outputs/flags=0.
//     clear_sat coincident with a sat event -> sat_flag=1, sat_count=1.

Source files
------------

// File: rtl/iq_mixer_pkg.sv
// Shared definitions for the I/Q mixer.
// Purpose : default widths, derived-width helpers and the shared
//           round-and-saturate function used by both mixer channels.
// Contents: CALC_W       internal arithmetic width for rounding/saturation
//           PROD_W       LO_WIDTH+RF_WIDTH for the default configuration
//           SCALED_W     PROD_W plus the largest gain shift (default config)
//           sat_round()  round half toward +inf after dropping 'drop' LSBs,
//                        then clip to a signed 'out_w'-bit range
package iq_mixer_pkg;

   localparam int LO_WIDTH_DEF     = 12;
   localparam int RF_WIDTH_DEF     = 1;
   localparam int OUT_WIDTH_DEF    = 12;
   localparam int RF_DELAY_DEF     = 2;
   localparam int GAIN_SHIFT_W_DEF = 2;
   localparam int SAT_CNT_W_DEF    = 16;

   // Wide enough for any sensible LO/RF/shift combination, so the
   // rounding add can never overflow before saturation.
   localparam int CALC_W = 64;

   function automatic int prod_width(input int lo_w, input int rf_w);
      return lo_w + rf_w;
   endfunction

   function automatic int scaled_width(input int prod_w, input int gain_shift_w);
      return prod_w + (1 << gain_shift_w) - 1;
   endfunction

   localparam int PROD_W   = prod_width(LO_WIDTH_DEF, RF_WIDTH_DEF);
   localparam int SCALED_W = scaled_width(PROD_W, GAIN_SHIFT_W_DEF);

   typedef struct packed {
      logic                     sat;
      logic signed [CALC_W-1:0] value;
   } sat_round_t;

   function automatic sat_round_t sat_round(input logic signed [CALC_W-1:0] value,
                                            input int drop,
                                            input int out_w);
      logic signed [CALC_W-1:0] rounded;
      logic signed [CALC_W-1:0] max_v;
      logic signed [CALC_W-1:0] min_v;
      sat_round_t               res;
      rounded = value;
      // Adding half an output LSB before the arithmetic shift rounds
      // exact halves toward +inf.
      if (drop > 0) begin
         rounded = (value + (CALC_W'(1) <<< (drop - 1))) >>> drop;
      end
      max_v     = (CALC_W'(1) <<< (out_w - 1)) - CALC_W'(1);
      min_v     = -(CALC_W'(1) <<< (out_w - 1));
      res.sat   = 1'b0;
      res.value = rounded;
      if (rounded > max_v) begin
         res.sat   = 1'b1;
         res.value = max_v;
      end else if (rounded < min_v) begin
         res.sat   = 1'b1;
         res.value = min_v;
      end
      return res;
   endfunction

endpackage

// File: rtl/iq_mixer_pipelined_scale_sat.sv
// One output channel of the mixer: gain shift, rounding and saturation.
// Purpose : takes a stage-1 product and its captured gain shift, produces a
//           registered OUT_WIDTH result that only updates when en=1.
// Ports   : clk, rst   clock, synchronous active-high reset
//           en         stage-2 valid; result register loads only when set
//           prod       signed product from stage 1 (IN_W bits)
//           shift      gain shift captured together with prod
//           result     registered, rounded, saturated output (holds when !en)
//           sat        combinational: this channel's current input clips
module mixer_scale_sat
   import iq_mixer_pkg::*;
#(
   parameter int IN_W         = PROD_W,
   parameter int SCALE_W      = SCALED_W,
   parameter int GAIN_SHIFT_W = GAIN_SHIFT_W_DEF,
   parameter int DROP         = RF_WIDTH_DEF - 1,
   parameter int OUT_WIDTH    = OUT_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [IN_W-1:0]         prod,
   input  logic [GAIN_SHIFT_W-1:0] shift,
   output logic [OUT_WIDTH-1:0]    result,
   output logic                    sat
);

   logic signed [SCALE_W-1:0] scaled;
   sat_round_t                rnd;
   logic [OUT_WIDTH-1:0]      result_d;
   logic [OUT_WIDTH-1:0]      result_q;

   always_comb begin
      // SCALE_W leaves room for the largest shift, so no bits are lost.
      scaled   = SCALE_W'($signed(prod)) <<< shift;
      rnd      = sat_round(CALC_W'(scaled), DROP, OUT_WIDTH);
      sat      = rnd.sat;
      result_d = en ? OUT_WIDTH'(rnd.value) : result_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: rtl/iq_mixer_pipelined.sv
// I/Q mixer: RF sample stream times NCO sine/cosine.
// Purpose : delays rf_in to line up with the LO, multiplies (stage 1),
//           scales/rounds/saturates each channel (stage 2), and keeps a
//           sticky saturation flag plus a saturating event counter.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           rf_in                    RF sample (1 bit: 0=+1, 1=-1; else signed Q1.x)
//           in_valid                 LO inputs valid this cycle
//           sinewave_in/cosinewave_in signed NCO samples
//           gain_shift               post-multiply left shift, captured per sample
//           clear_sat                pulse: clears sat_flag/sat_count
//           rf_out                   rf_in delayed one clock
//           out_valid                mixed outputs carry a new sample
//           sinewave_out/cosinewave_out signed mixed products
//           sat_flag, sat_count      sticky flag and saturating clip counter
// Valid semantics: in_valid qualifies the LO inputs on the edge it is high;
// out_valid is in_valid delayed by exactly two registers; there is no ready,
// the consumer must accept every valid output; outputs hold when out_valid=0.
module iq_mixer_pipelined
   import iq_mixer_pkg::*;
#(
   parameter int LO_WIDTH     = LO_WIDTH_DEF,
   parameter int RF_WIDTH     = RF_WIDTH_DEF,
   parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
   parameter int RF_DELAY     = RF_DELAY_DEF,
   parameter int GAIN_SHIFT_W = GAIN_SHIFT_W_DEF,
   parameter int SAT_CNT_W    = SAT_CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [RF_WIDTH-1:0]     rf_in,
   input  logic                    in_valid,
   input  logic [LO_WIDTH-1:0]     sinewave_in,
   input  logic [LO_WIDTH-1:0]     cosinewave_in,
   input  logic [GAIN_SHIFT_W-1:0] gain_shift,
   input  logic                    clear_sat,
   output logic [RF_WIDTH-1:0]     rf_out,
   output logic                    out_valid,
   output logic [OUT_WIDTH-1:0]    sinewave_out,
   output logic [OUT_WIDTH-1:0]    cosinewave_out,
   output logic                    sat_flag,
   output logic [SAT_CNT_W-1:0]    sat_count
);

   localparam int PW   = prod_width(LO_WIDTH, RF_WIDTH);
   localparam int SW   = scaled_width(PW, GAIN_SHIFT_W);
   localparam int DROP = RF_WIDTH - 1;

   // Delay line: index 0 is the 1-clock tap, RF_DELAY-1 feeds the multiplier.
   logic [RF_WIDTH-1:0]     rf_dly_d [RF_DELAY];
   logic [RF_WIDTH-1:0]     rf_dly_q [RF_DELAY];
   logic [RF_WIDTH-1:0]     rf_tap;

   logic signed [PW-1:0]    lo_s_ext, lo_c_ext;
   logic signed [PW-1:0]    mul_s, mul_c;
   logic signed [PW-1:0]    prod_s_d, prod_s_q;
   logic signed [PW-1:0]    prod_c_d, prod_c_q;
   logic [GAIN_SHIFT_W-1:0] shift_d, shift_q;
   logic                    v1_d, v1_q;
   logic                    out_valid_d, out_valid_q;
   logic                    sat_s, sat_c, sat_event;
   logic                    sat_flag_d, sat_flag_q;
   logic [SAT_CNT_W-1:0]    sat_count_d, sat_count_q;

   // RF delay line shifts every clock, independent of in_valid.
   always_comb begin
      rf_dly_d[0] = rf_in;
      for (int i = 1; i < RF_DELAY; i++) begin
         rf_dly_d[i] = rf_dly_q[i-1];
      end
   end

   assign rf_tap = rf_dly_q[RF_DELAY-1];

   // Stage 1: multiply. In sign mode the product is just +/-lo; the extra
   // product bit makes -(-2^(LO_WIDTH-1)) representable.
   always_comb begin
      lo_s_ext = PW'($signed(sinewave_in));
      lo_c_ext = PW'($signed(cosinewave_in));
      if (RF_WIDTH == 1) begin
         mul_s = rf_tap[0] ? -lo_s_ext : lo_s_ext;
         mul_c = rf_tap[0] ? -lo_c_ext : lo_c_ext;
      end else begin
         mul_s = lo_s_ext * PW'($signed(rf_tap));
         mul_c = lo_c_ext * PW'($signed(rf_tap));
      end
      // Shift is captured with the sample so a change never splits one.
      prod_s_d    = in_valid ? mul_s : prod_s_q;
      prod_c_d    = in_valid ? mul_c : prod_c_q;
      shift_d     = in_valid ? gain_shift : shift_q;
      v1_d        = in_valid;
      out_valid_d = v1_q;
   end

   mixer_scale_sat #(
      .IN_W         (PW),
      .SCALE_W      (SW),
      .GAIN_SHIFT_W (GAIN_SHIFT_W),
      .DROP         (DROP),
      .OUT_WIDTH    (OUT_WIDTH)
   ) u_sin (
      .clk    (clk),
      .rst    (rst),
      .en     (v1_q),
      .prod   (prod_s_q),
      .shift  (shift_q),
      .result (sinewave_out),
      .sat    (sat_s)
   );

   mixer_scale_sat #(
      .IN_W         (PW),
      .SCALE_W      (SW),
      .GAIN_SHIFT_W (GAIN_SHIFT_W),
      .DROP         (DROP),
      .OUT_WIDTH    (OUT_WIDTH)
   ) u_cos (
      .clk    (clk),
      .rst    (rst),
      .en     (v1_q),
      .prod   (prod_c_q),
      .shift  (shift_q),
      .result (cosinewave_out),
      .sat    (sat_c)
   );

   // Saturation bookkeeping updates on the same edge the clipped sample is
   // registered. A coincident set overrides clear, leaving a count of one.
   always_comb begin
      sat_event   = v1_q & (sat_s | sat_c);
      sat_flag_d  = sat_flag_q;
      sat_count_d = sat_count_q;
      if (clear_sat) begin
         sat_flag_d  = 1'b0;
         sat_count_d = '0;
      end
      if (sat_event) begin
         sat_flag_d = 1'b1;
         if (sat_count_d != {SAT_CNT_W{1'b1}}) begin
            sat_count_d = sat_count_d + SAT_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RF_DELAY; i++) begin
            rf_dly_q[i] <= '0;
         end
         prod_s_q    <= '0;
         prod_c_q    <= '0;
         shift_q     <= '0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         sat_flag_q  <= 1'b0;
         sat_count_q <= '0;
      end else begin
         for (int i = 0; i < RF_DELAY; i++) begin
            rf_dly_q[i] <= rf_dly_d[i];
         end
         prod_s_q    <= prod_s_d;
         prod_c_q    <= prod_c_d;
         shift_q     <= shift_d;
         v1_q        <= v1_d;
         out_valid_q <= out_valid_d;
         sat_flag_q  <= sat_flag_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign rf_out    = rf_dly_q[0];
   assign out_valid = out_valid_q;
   assign sat_flag  = sat_flag_q;
   assign sat_count = sat_count_q;

endmodule

// File: tb/tb_iq_mixer_pipelined.sv
// Directed bench for iq_mixer_pipelined: a sign-mode instance (RF_WIDTH=1)
// and a multi-bit instance (RF_WIDTH=8, 2-bit saturation counter) share the
// LO/control stimulus; each checked vector targets one of them.
module tb_iq_mixer_pipelined;

   localparam int RD = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid;
   logic        clear_sat;
   logic [11:0] sin_in, cos_in;
   logic [1:0]  gain_shift;
   logic        rf_a;
   logic [7:0]  rf_b;

   logic        rf_out_a, out_valid_a, sat_flag_a;
   logic [11:0] sin_out_a, cos_out_a;
   logic [15:0] sat_count_a;

   logic [7:0]  rf_out_b;
   logic        out_valid_b, sat_flag_b;
   logic [11:0] sin_out_b, cos_out_b;
   logic [1:0]  sat_count_b;

   iq_mixer_pipelined #(.RF_WIDTH(1), .RF_DELAY(RD)) dut_a (
      .clk(clk), .rst(rst), .rf_in(rf_a), .in_valid(in_valid),
      .sinewave_in(sin_in), .cosinewave_in(cos_in), .gain_shift(gain_shift),
      .clear_sat(clear_sat), .rf_out(rf_out_a), .out_valid(out_valid_a),
      .sinewave_out(sin_out_a), .cosinewave_out(cos_out_a),
      .sat_flag(sat_flag_a), .sat_count(sat_count_a)
   );

   iq_mixer_pipelined #(.RF_WIDTH(8), .RF_DELAY(RD), .SAT_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .rf_in(rf_b), .in_valid(in_valid),
      .sinewave_in(sin_in), .cosinewave_in(cos_in), .gain_shift(gain_shift),
      .clear_sat(clear_sat), .rf_out(rf_out_b), .out_valid(out_valid_b),
      .sinewave_out(sin_out_b), .cosinewave_out(cos_out_b),
      .sat_flag(sat_flag_b), .sat_count(sat_count_b)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [11:0] exp_q[$];

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // Pop the next expected sine sample and compare it with DUT A.
   task automatic check_pop_a(input string name);
      if (exp_q.size() == 0) begin
         check({name, "_unexpected_valid"}, 1, 0);
      end else begin
         check(name, $signed(sin_out_a), $signed(exp_q.pop_front()));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rf(input logic [7:0] rf);
      rf_a     = rf[0];
      rf_b     = rf;
      in_valid = 1'b0;
      for (int i = 0; i < RD; i++) step();
   endtask

   typedef struct {
      bit          sel;      // 0 = sign-mode DUT A, 1 = 8-bit DUT B
      logic [7:0]  rf;
      int          sin_v;
      int          cos_v;
      int          sh;
      int          exp_s;
      int          exp_c;
      int          exp_sat;
   } vec_t;

   vec_t vecs[12];

   task automatic run_vec(input vec_t v, input int idx);
      gain_shift = 2'(v.sh);
      clear_sat  = 1'b1;
      rf_a       = v.rf[0];
      rf_b       = v.rf;
      in_valid   = 1'b0;
      step();
      clear_sat  = 1'b0;
      for (int i = 1; i < RD; i++) step();
      sin_in   = 12'(v.sin_v);
      cos_in   = 12'(v.cos_v);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      if (v.sel) begin
         check($sformatf("vec%0d_valid", idx), out_valid_b, 1);
         check($sformatf("vec%0d_sin", idx), $signed(sin_out_b), v.exp_s);
         check($sformatf("vec%0d_cos", idx), $signed(cos_out_b), v.exp_c);
         check($sformatf("vec%0d_flag", idx), sat_flag_b, v.exp_sat);
         check($sformatf("vec%0d_count", idx), sat_count_b, v.exp_sat);
      end else begin
         check($sformatf("vec%0d_valid", idx), out_valid_a, 1);
         check($sformatf("vec%0d_sin", idx), $signed(sin_out_a), v.exp_s);
         check($sformatf("vec%0d_cos", idx), $signed(cos_out_a), v.exp_c);
         check($sformatf("vec%0d_flag", idx), sat_flag_a, v.exp_sat);
         check($sformatf("vec%0d_count", idx), sat_count_a, v.exp_sat);
      end
   endtask

   // ---------------- test body ----------------
   int   rf_h[64];
   int   v_h[64];
   int   tap;
   int   last_sin;
   bit   have_last;

   initial begin
      //         sel rf      sin    cos    sh  exp_s  exp_c  sat
      vecs[0]  = '{1'b0, 8'd0,   100,  -200,  0,   100,  -200, 0};
      vecs[1]  = '{1'b0, 8'd1,   100,  -200,  0,  -100,   200, 0};
      vecs[2]  = '{1'b0, 8'd1, -2048,     0,  0,  2047,     0, 1};
      vecs[3]  = '{1'b0, 8'd0,   600,     0,  2,  2047,     0, 1};
      vecs[4]  = '{1'b0, 8'd0,  -300,   100,  1,  -600,   200, 0};
      vecs[5]  = '{1'b0, 8'd0, -2048,  2047,  0, -2048,  2047, 0};
      vecs[6]  = '{1'b0, 8'd0,  -300,     1,  3, -2048,     8, 1};
      vecs[7]  = '{1'b1, 8'd64, 1000, -1000,  0,   500,  -500, 0};
      vecs[8]  = '{1'b1, 8'd1,    64,   -64,  0,     1,     0, 0};
      vecs[9]  = '{1'b1, 8'd1,    63,   -65,  0,     0,    -1, 0};
      vecs[10] = '{1'b1, 8'h80, -2048, 2047,  0,  2047, -2047, 1};
      vecs[11] = '{1'b1, 8'd127, 2047, -2048, 1,  2047, -2048, 1};

      rst = 1'b1; in_valid = 1'b0; clear_sat = 1'b0;
      sin_in = '0; cos_in = '0; gain_shift = '0; rf_a = 1'b0; rf_b = '0;
      step(); step();

      // Reset state
      check("reset_valid", out_valid_a, 0);
      check("reset_sin", sin_out_a, 0);
      check("reset_cos", cos_out_a, 0);
      check("reset_flag", sat_flag_a, 0);
      check("reset_count", sat_count_a, 0);
      check("reset_rf_out", rf_out_a, 0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Streaming: rf toggles, in_valid has gaps, signs follow delayed rf.
      clear_sat = 1'b0; gain_shift = 2'd0;
      sin_in = 12'd100; cos_in = -12'sd200;
      fill_rf(8'd0);
      step();
      have_last = 1'b0;
      for (int n = 0; n < 24; n++) begin
         rf_a     = (n % 2 == 1);
         in_valid = !((n % 7 == 3) || (n % 7 == 4));
         rf_h[n]  = int'(rf_a);
         v_h[n]   = int'(in_valid);
         if (in_valid) begin
            tap = (n >= RD) ? rf_h[n-RD] : 0;
            exp_q.push_back((tap != 0) ? -12'sd100 : 12'sd100);
         end
         step();
         check("stream_rf_out", rf_out_a, rf_h[n]);
         if (n >= 1) check("stream_valid", out_valid_a, v_h[n-1]);
         if (out_valid_a) begin
            last_sin  = $signed(exp_q[0]);
            have_last = 1'b1;
            check_pop_a("stream_sin");
         end else if (have_last) begin
            check("stream_hold", $signed(sin_out_a), last_sin);
         end
      end
      in_valid = 1'b0;
      step();
      if (out_valid_a) check_pop_a("stream_drain");
      step();
      check("stream_queue_empty", exp_q.size(), 0);

      // Gain shift changes every sample; each sample keeps its own shift.
      fill_rf(8'd0);
      sin_in = 12'd300; cos_in = 12'd0;
      for (int k = 0; k < 5; k++) begin
         in_valid   = (k < 3);
         gain_shift = 2'(k);
         if (k < 3) exp_q.push_back(12'(300 << k));
         step();
         if (out_valid_a) check_pop_a("gain_sample");
      end
      check("gain_queue_empty", exp_q.size(), 0);
      gain_shift = 2'd0;

      // Counter sticks at all-ones on the 2-bit instance.
      clear_sat = 1'b1; step(); clear_sat = 1'b0;
      fill_rf(8'h80);
      sin_in = -12'sd2048;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) step();
      in_valid = 1'b0;
      step(); step();
      check("cnt_stick_count", sat_count_b, 3);
      check("cnt_stick_flag", sat_flag_b, 1);
      check("cnt_no_sat_a", sat_count_a, 0);

      // clear_sat coincident with a saturation event: set wins, count = 1.
      clear_sat = 1'b1; step(); clear_sat = 1'b0;
      check("clear_flag", sat_flag_a, 0);
      check("clear_count", sat_count_a, 0);
      fill_rf(8'd1);
      sin_in = -12'sd2048; in_valid = 1'b1;
      step();
      step();
      check("coinc_pre1", sat_count_a, 1);
      step();
      check("coinc_pre2", sat_count_a, 2);
      in_valid = 1'b0; clear_sat = 1'b1;
      step();
      clear_sat = 1'b0;
      check("coinc_flag", sat_flag_a, 1);
      check("coinc_count", sat_count_a, 1);
      step();
      check("coinc_hold_count", sat_count_a, 1);
      check("coinc_idle_valid", out_valid_a, 0);

      // Reset while the pipeline is full.
      sin_in = -12'sd2048; in_valid = 1'b1;
      step(); step(); step();
      rst = 1'b1;
      step();
      check("midrst_valid", out_valid_a, 0);
      check("midrst_sin", sin_out_a, 0);
      check("midrst_cos", cos_out_a, 0);
      check("midrst_flag", sat_flag_a, 0);
      check("midrst_count", sat_count_a, 0);
      check("midrst_rf_out", rf_out_a, 0);
      // Zeroed delay line means +1 even though rf_in is now 1.
      rst = 1'b0; rf_a = 1'b1; sin_in = 12'd100; in_valid = 1'b1;
      step();
      check("postrst_valid0", out_valid_a, 0);
      in_valid = 1'b0;
      step();
      check("postrst_valid1", out_valid_a, 1);
      check("postrst_sin", $signed(sin_out_a), 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
